// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, timing defaults and host-tx state encoding
package ps2_pkg;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // Timing defaults for a 50 MHz fpgaclock
  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;
  localparam int DEF_FILTER_LEN     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_t;

  // PS/2 uses odd parity: data plus parity always holds an odd number of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchronizer, debounce and falling-edge pulse for one PS/2 line
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic fpgaclock,
  input  logic reset,
  input  logic line_in,
  output logic filt,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; resets to the idle-high level so reset never fabricates an edge
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
    end
  end

  // Debounce: filt follows sync only after FILTER_LEN consecutive differing samples
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      filt <= 1'b1;
      cnt  <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync;
        cnt  <= '0;
        fall <= ~sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       fpgaclock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  // The start bit is driven by the request itself, so the shifter holds the remaining bits
  localparam int SH_BITS = FRAME_BITS - 1;
  localparam int IW      = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

  tx_state_t          state;
  logic [SH_BITS-1:0] sh;
  logic [3:0]         bitcnt;
  logic [IW-1:0]      inh_cnt;
  logic [TW-1:0]      to_cnt;
  logic               c_filt;
  logic               c_fall;
  logic               d_meta;
  logic               d_sync;
  logic               timed;
  logic               tmo_hit;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .fpgaclock(fpgaclock),
    .reset    (reset),
    .line_in  (ps2c_in),
    .filt     (c_filt),
    .fall     (c_fall)
  );

  // Bare two-flop synchronizer on ps2d; it is only sampled on filtered clock edges
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      d_meta <= ps2d_in;
      d_sync <= d_meta;
    end
  end

  assign timed   = (state == ST_REQ) || (state == ST_DATA) ||
                   (state == ST_ACK) || (state == ST_WAIT_IDLE);
  assign tmo_hit = timed && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Frame sequencer with registered line enables and status pulses
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      state    <= ST_IDLE;
      sh       <= '0;
      bitcnt   <= '0;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      ps2c_oe  <= 1'b0;
      ps2d_oe  <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (tmo_hit) begin
        // Device stopped responding: release both lines and report failure
        ps2c_oe  <= 1'b0;
        ps2d_oe  <= 1'b0;
        tx_busy  <= 1'b0;
        tx_done  <= 1'b1;
        tx_error <= 1'b1;
        state    <= ST_IDLE;
      end else begin
        if (timed) to_cnt <= to_cnt + 1'b1;
        case (state)
          ST_IDLE: begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            if (tx_start) begin
              sh      <= {1'b1, odd_parity(tx_data), tx_data};
              inh_cnt <= '0;
              ps2c_oe <= 1'b1;
              tx_busy <= 1'b1;
              state   <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
              ps2c_oe <= 1'b0;
              ps2d_oe <= 1'b1;
              to_cnt  <= '0;
              bitcnt  <= '0;
              state   <= ST_REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          ST_REQ: begin
            // First device clock has consumed the start bit; present data bit 0
            if (c_fall) begin
              ps2d_oe <= ~sh[0];
              bitcnt  <= 4'd1;
              state   <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (c_fall) begin
              ps2d_oe <= ~sh[bitcnt];
              if (bitcnt == 4'(SH_BITS - 1)) state  <= ST_ACK;
              else                           bitcnt <= bitcnt + 1'b1;
            end
          end
          ST_ACK: begin
            if (c_fall) begin
              if (d_sync) begin
                tx_busy  <= 1'b0;
                tx_done  <= 1'b1;
                tx_error <= 1'b1;
                ps2d_oe  <= 1'b0;
                state    <= ST_IDLE;
              end else begin
                state <= ST_WAIT_IDLE;
              end
            end
          end
          ST_WAIT_IDLE: begin
            if (c_filt && d_sync) begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
              state   <= ST_IDLE;
            end
          end
          default: begin
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            tx_busy <= 1'b0;
            state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 4000;
  localparam int FLT  = 2;
  localparam int HALF = 30;

  logic       fpgaclock;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       bfm_c;
  logic       bfm_d;

  int         vectors     = 0;
  int         miscompares = 0;
  int         done_cnt    = 0;
  int         err_cnt     = 0;
  logic [1:0] oe_at_done  = 2'b11;
  logic       err_at_done = 1'b0;
  int         d0;
  int         e0;
  int         n;

  // Open-collector wired-AND of host and device
  assign ps2c_in = bfm_c & ~ps2c_oe;
  assign ps2d_in = bfm_d & ~ps2d_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FLT)
  ) dut (
    .fpgaclock(fpgaclock),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_error (tx_error)
  );

  initial begin
    fpgaclock = 1'b0;
    forever #5 fpgaclock = ~fpgaclock;
  end

  always @(negedge fpgaclock) begin
    if (tx_done) begin
      done_cnt    = done_cnt + 1;
      oe_at_done  = {ps2c_oe, ps2d_oe};
      err_at_done = tx_error;
    end
    if (tx_error) err_cnt = err_cnt + 1;
  end

  task automatic tick;
    @(posedge fpgaclock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
  endtask

  // Device side of one frame; exp is {stop, parity, data[7:0]} as seen on the wire
  task automatic device_frame(input string tag, input logic [9:0] exp, input bit nack,
                              input bit glitch, input int abort_at);
    logic [9:0] got;
    logic       b;
    int         w;
    got = '0;
    w   = 0;
    while (!(ps2c_oe == 1'b0 && ps2d_oe == 1'b1) && w < 500) begin
      tick;
      w++;
    end
    check({tag, " request"}, {ps2c_oe, ps2d_oe}, 2'b01);
    check({tag, " start bit"}, ps2d_in, 0);
    repeat (5) tick;
    for (int i = 0; i < 10; i++) begin
      bfm_c = 1'b0;
      if (i == abort_at) begin
        repeat (10) tick;
        b = ~exp[i];
        check({tag, " mid-bit oe"}, ps2d_oe, b);
        reset = 1'b1;
        tick;
        check({tag, " reset lines"}, {ps2c_oe, ps2d_oe}, 0);
        check({tag, " reset busy"}, tx_busy, 0);
        reset = 1'b0;
        bfm_c = 1'b1;
        return;
      end
      repeat (HALF) tick;
      got[i] = ps2d_in;
      bfm_c  = 1'b1;
      if (glitch && i == 3) begin
        repeat (10) tick;
        bfm_c = 1'b0;
        tick;
        bfm_c = 1'b1;
        repeat (HALF - 11) tick;
      end else begin
        repeat (HALF) tick;
      end
    end
    check({tag, " frame bits"}, got, exp);
    if (!nack) bfm_d = 1'b0;
    repeat (5) tick;
    bfm_c = 1'b0;
    repeat (HALF) tick;
    bfm_c = 1'b1;
    bfm_d = 1'b1;
    repeat (HALF) tick;
  endtask

  task automatic expect_end(input string tag, input int dc, input int ec, input int errs,
                            input logic err_flag);
    int w;
    w = 0;
    while (tx_busy && w < 500) begin
      tick;
      w++;
    end
    tick;
    check({tag, " busy low"}, tx_busy, 0);
    check({tag, " done pulses"}, done_cnt - dc, 1);
    check({tag, " error cycles"}, err_cnt - ec, errs);
    check({tag, " error at done"}, err_at_done, err_flag);
    check({tag, " lines at done"}, oe_at_done, 0);
  endtask

  initial begin
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    bfm_c    = 1'b1;
    bfm_d    = 1'b1;
    repeat (3) tick;
    check("reset ps2c_oe", ps2c_oe, 0);
    check("reset ps2d_oe", ps2d_oe, 0);
    check("reset tx_busy", tx_busy, 0);
    check("reset tx_done", tx_done, 0);
    check("reset tx_error", tx_error, 0);

    tx_start = 1'b1;
    tx_data  = 8'hED;
    tick;
    check("reset beats start busy", tx_busy, 0);
    check("reset beats start oe", ps2c_oe, 0);
    tx_start = 1'b0;
    reset    = 1'b0;
    repeat (5) tick;

    // 0xED with ACK, inhibit width measured
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hED);
    check("accept busy", tx_busy, 1);
    check("accept ps2c_oe", ps2c_oe, 1);
    n = 0;
    while (ps2c_oe && n < 100) begin
      n++;
      tick;
    end
    check("inhibit length", n, 20);
    device_frame("ed", 10'b11_1110_1101, 1'b0, 1'b0, -1);
    expect_end("ed", d0, e0, 0, 1'b0);

    // 0x00 with a start request while busy
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h00);
    repeat (3) tick;
    tx_data  = 8'hAA;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
    check("start while busy", tx_busy, 1);
    device_frame("p00", 10'b11_0000_0000, 1'b0, 1'b0, -1);
    expect_end("p00", d0, e0, 0, 1'b0);
    repeat (50) tick;
    check("no queued frame", tx_busy, 0);

    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h01);
    device_frame("p01", 10'b10_0000_0001, 1'b0, 1'b0, -1);
    expect_end("p01", d0, e0, 0, 1'b0);

    // 0xFF with a one-cycle clock glitch during bit 3
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'hFF);
    device_frame("pff", 10'b11_1111_1111, 1'b0, 1'b1, -1);
    expect_end("pff", d0, e0, 0, 1'b0);

    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h80);
    device_frame("p80", 10'b10_1000_0000, 1'b0, 1'b0, -1);
    expect_end("p80", d0, e0, 0, 1'b0);

    // Device refuses the byte
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h00);
    device_frame("nack", 10'b11_0000_0000, 1'b1, 1'b0, -1);
    expect_end("nack", d0, e0, 1, 1'b1);

    // Device never clocks
    d0 = done_cnt;
    e0 = err_cnt;
    start_tx(8'h55);
    n = 0;
    while (!ps2d_oe && n < 200) begin
      tick;
      n++;
    end
    check("timeout request", ps2d_oe, 1);
    n = 0;
    while (!tx_done && n < 5000) begin
      tick;
      n++;
    end
    check("timeout latency", n, 4000);
    check("timeout error", tx_error, 1);
    check("timeout lines", {ps2c_oe, ps2d_oe}, 0);
    tick;
    check("timeout done width", tx_done, 0);
    check("timeout busy", tx_busy, 0);
    check("timeout error cycles", err_cnt - e0, 1);

    // Reset while data bit 4 (a zero, so ps2d is held low) is on the wire
    d0 = done_cnt;
    start_tx(8'hEF);
    device_frame("abort", 10'b10_1110_1111, 1'b0, 1'b0, 4);
    repeat (10) tick;
    check("abort no done", done_cnt - d0, 0);
    check("abort idle busy", tx_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
